output_display: RTL



---
 rtl/output_display.sv | 111 +++++++++++
 1 files changed

// File: rtl/output_display.sv
// Hex display driver: latches a 16-bit word, scans it over 4 digits, mirrors PC LEDs.
// Optional macro OUTPUT_DISPLAY_GHOST_GUARD_EN blanks the first cycle of each slot.
module output_display #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_cpu_n,
    input  logic [15:0] data_in,
    input  logic [7:0]  pc_in,
    input  logic        load,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic [7:0]  led
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic DP_OFF = SEG_ACTIVE_LOW;

    logic [PW-1:0] presc;
    logic [1:0]    idx;
    logic [15:0]   latch;
    logic          loaded;

    logic [3:0] nib;
    logic [6:0] glyph;
    logic [6:0] seg_nxt;
    logic       dp_on;
    logic       dp_nxt;
    logic [3:0] an_nxt;

    // Prescaler, digit index and capture latch.
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) begin
            presc  <= '0;
            idx    <= 2'd0;
            latch  <= 16'h0000;
            loaded <= 1'b0;
        end else begin
            if (presc == P_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + PW'(1);
            end
            if (load) begin
                latch  <= data_in;
                loaded <= 1'b1;
            end
        end
    end

    // Glyph, decimal point and anode selection for the current digit.
    always_comb begin
        nib    = latch[{idx, 2'b00} +: 4];
        glyph  = 7'h00;
        case (nib)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            4'hF: glyph = 7'h71;
            default: glyph = 7'h00;
        endcase
        seg_nxt = SEG_ACTIVE_LOW ? ~glyph : glyph;
        dp_on   = (idx == 2'd3) && !loaded;
        dp_nxt  = SEG_ACTIVE_LOW ? ~dp_on : dp_on;
        an_nxt  = ~(4'b0001 << idx);
        if (blank) begin
            an_nxt = 4'b1111;
        end
`ifdef OUTPUT_DISPLAY_GHOST_GUARD_EN
        // Dead cycle at slot start so the old glyph never shows on the new digit.
        if (presc == '0) begin
            an_nxt = 4'b1111;
        end
`else
`endif
    end

    // Output registers: one cycle behind index and latch.
    always_ff @(posedge clk) begin
        if (!reset_cpu_n) begin
            seg <= SEG_OFF;
            dp  <= DP_OFF;
            an  <= 4'b1111;
            led <= 8'h00;
        end else begin
            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
            led <= pc_in;
        end
    end

endmodule
